// File: rtl/preact_pkg.sv
// Shared types for the pre-activation + sigmoid pipeline: operation modes and their width.
package preact_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_AUTO    = 2'd0,
      MODE_ADD     = 2'd1,
      MODE_ABSDIFF = 2'd2,
      MODE_SUB     = 2'd3
   } mode_e;

endpackage

// File: rtl/sigmoid_pwl.sv
// One-lane piecewise-linear sigmoid over an unsigned input: three segments with slopes 1/2, 1/4, 1/8.
module sigmoid_pwl #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] x,
   output logic [DATA_W-1:0] y
);

   localparam logic [DATA_W-1:0] H = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] Q = {2'b01, {(DATA_W-2){1'b0}}};

   // Segment offsets chain so the curve is continuous at x=Q and x=H.
   always_comb begin
      y = '0;
      if (x < Q) begin
         y = H + (x >> 1);
      end else if (x < H) begin
         y = H + (Q >> 1) + ((x - Q) >> 2);
      end else begin
         y = H + (Q >> 1) + (Q >> 2) + ((x - H) >> 3);
      end
   end

endmodule

// File: rtl/preact_sigmoid_pipe.sv
// Multi-lane pre-activation (add / |diff| / floored sub) followed by a PWL sigmoid, two-stage valid/ready pipe.
// Define PREACT_SAT_EN to clamp sum overflow to all-ones (with out_sat); otherwise sums wrap.
module preact_sigmoid_pipe
   import preact_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int THRESH = 63
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [MODE_W-1:0]        in_mode,
   input  logic [LANES*DATA_W-1:0]  in_a,
   input  logic [LANES*DATA_W-1:0]  in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*DATA_W-1:0]  out_y,
   output logic [LANES-1:0]         out_sat
);

   localparam int BUS_W = LANES * DATA_W;
   localparam logic [DATA_W-1:0] THRESH_V = DATA_W'(THRESH);

   // Returns {overflow_flag, value} for a DATA_W+1 bit sum.
   function automatic logic [DATA_W:0] fit_sum(input logic [DATA_W:0] sum);
`ifdef PREACT_SAT_EN
      if (sum[DATA_W]) fit_sum = {1'b1, {DATA_W{1'b1}}};
      else             fit_sum = sum;
`else
      fit_sum = sum & {1'b0, {DATA_W{1'b1}}};
`endif
   endfunction

   logic [BUS_W-1:0] pre_bus, sig_bus, pre_p1, y_p2;
   logic [LANES-1:0] pre_sat, sat_p1, sat_p2;
   logic             vld_p1, vld_p2, adv_p2;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [DATA_W-1:0] a, b, absd, lane_pre;
      logic [DATA_W:0]   sum, fit;
      logic              a_ge_b, lane_sat;

      assign a      = in_a[i*DATA_W +: DATA_W];
      assign b      = in_b[i*DATA_W +: DATA_W];
      assign sum    = {1'b0, a} + {1'b0, b};
      assign a_ge_b = (a >= b);
      assign absd   = a_ge_b ? (a - b) : (b - a);
      assign fit    = fit_sum(sum);

      always_comb begin
         lane_pre = '0;
         lane_sat = 1'b0;
         case (mode_e'(in_mode))
            MODE_AUTO: begin
               if (b > THRESH_V) {lane_sat, lane_pre} = fit;
               else              lane_pre = absd;
            end
            MODE_ADD:     {lane_sat, lane_pre} = fit;
            MODE_ABSDIFF: lane_pre = absd;
            MODE_SUB: begin
               if (a_ge_b) lane_pre = absd;
               else        lane_sat = 1'b1;
            end
            default: lane_pre = '0;
         endcase
      end

      assign pre_bus[i*DATA_W +: DATA_W] = lane_pre;
      assign pre_sat[i]                  = lane_sat;

      sigmoid_pwl #(.DATA_W(DATA_W)) u_sig (
         .x (pre_p1[i*DATA_W +: DATA_W]),
         .y (sig_bus[i*DATA_W +: DATA_W])
      );
   end

   assign adv_p2   = !vld_p2 || out_ready;
   assign in_ready = !reset && (!vld_p1 || adv_p2);

   // Stage 1: pre-activation register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1 <= 1'b0;
         pre_p1 <= '0;
         sat_p1 <= '0;
      end else if (in_ready) begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            pre_p1 <= pre_bus;
            sat_p1 <= pre_sat;
         end
      end
   end

   // Stage 2: sigmoid output register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p2 <= 1'b0;
         y_p2   <= '0;
         sat_p2 <= '0;
      end else if (adv_p2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            y_p2   <= sig_bus;
            sat_p2 <= sat_p1;
         end
      end
   end

   assign out_valid = vld_p2;
   assign out_y     = y_p2;
   assign out_sat   = sat_p2;

endmodule
